// File: rtl/inst_loader.sv
// Instruction-memory loader: accepts a valid/ready word stream and writes it into
// consecutive RAM addresses from 0, stopping at the halt word or at the last address.
module inst_loader #(
    parameter int A            = 10,
    parameter int W            = 10,
    parameter int STOP_ON_HALT = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadStart,
    input  logic [W-1:0] InData,
    input  logic         InValid,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Full,
    output logic [A:0]   WordCount,
    output logic [1:0]   DbgState
);

    // Handshake: a word moves when InValid && InReady in the same cycle; InReady is
    // combinational and does not depend on InValid, so the source may hold InValid high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [A-1:0] LAST_ADDR = '1;
    localparam logic [W-1:0] HALT_WORD = '1;
    localparam logic [A:0]   MAX_COUNT = {1'b1, {A{1'b0}}};
    localparam logic         HALT_EN   = (STOP_ON_HALT != 0);

    state_t         state_q, state_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [A:0]     count_q, count_d;
    logic           full_q, full_d;
    logic           wr_en_q, wr_en_d;
    logic [A-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]   wr_data_q, wr_data_d;

    logic           in_ready;
    logic           accept;
    logic           is_halt;

    assign in_ready = (state_q == ST_LOAD) && !LoadStart;
    assign accept   = InValid && in_ready;
    assign is_halt  = HALT_EN && (InData == HALT_WORD);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        full_d    = full_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (LoadStart) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (LoadStart) begin
                    addr_d  = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = InData;
                    addr_d    = addr_q + 1'b1;
                    count_d   = (count_q == MAX_COUNT) ? count_q : count_q + 1'b1;
                    // Halt wins over the full condition when both land on the last slot.
                    if (is_halt) begin
                        state_d = ST_DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        full_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign InReady   = in_ready;
    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign Busy      = (state_q == ST_LOAD);
    assign Done      = (state_q == ST_DONE);
    assign Full      = full_q;
    assign WordCount = count_q;
    assign DbgState  = state_q;

endmodule
